// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// synchronous flush (bubble insertion), optional 2-entry skid buffer and a saturating
// stall-cycle counter.
//
// Parameters:
//   WIDTH   - payload width
//   RST_VAL - bubble encoding driven on out_data whenever no valid entry is held
//   SKID    - 0: single entry, in_ready combinational from out_ready
//             1: two-entry skid buffer, in_ready registered
//   CNT_W   - width of stall_cnt
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (priority over flush)
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts a payload this cycle
//   in_data    in   upstream payload
//   flush      in   synchronous kill of all held entries
//   out_valid  out  out_data holds a valid payload
//   out_ready  in   downstream accepts this cycle
//   out_data   out  payload to next stage, RST_VAL when out_valid=0
//   stall_cnt  out  saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg #(
    parameter int unsigned       WIDTH   = 12,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter int unsigned       SKID    = 0,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    // StFull is only reachable with SKID != 0.
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               in_fire, out_fire;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        in_fire     = in_valid & in_ready;
        out_fire    = out_valid & out_ready;

        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_d  = in_data;
                end
            end
            StOne: begin
                if (in_fire && out_ready) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    // Only reachable with SKID != 0: in the single-entry mode in_ready
                    // while occupied implies out_ready.
                    state_d = StFull;
                    skid_d  = in_data;
                end else if (out_ready) begin
                    state_d = StEmpty;
                    main_d  = RST_VAL;
                end
            end
            StFull: begin
                // No input can be accepted here since in_ready is low.
                if (out_ready) begin
                    state_d = StOne;
                    main_d  = skid_q;
                    skid_d  = RST_VAL;
                end
            end
            default: begin
                state_d = StEmpty;
                main_d  = RST_VAL;
                skid_d  = RST_VAL;
            end
        endcase

        // Stall accounting sees the pre-flush occupancy.
        if (out_valid && !out_ready && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Flush discards everything, including a payload accepted this cycle.
        if (flush) begin
            state_d = StEmpty;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end

        in_ready_d = (state_d != StFull);
    end

    // Outputs
    always_comb begin
        out_valid = (state_q != StEmpty);
        // main_q is RST_VAL whenever the stage is empty, so no gating is needed.
        out_data  = main_q;
        stall_cnt = stall_cnt_q;
        if (SKID != 0) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = (state_q == StEmpty) | out_ready;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (single-entry with RST_VAL=0xABC, and
// skid buffer with RST_VAL=0, CNT_W=4) driven with the same stimulus, checked every
// cycle against a queue-based occupancy model plus literal expectations.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, flush, out_ready;
    logic [11:0] in_data;
    logic        ir0, ov0, ir1, ov1;
    logic [11:0] od0, od1;
    logic [15:0] sc0;
    logic [3:0]  sc1;

    pipe_stage_reg #(
        .WIDTH  (12),
        .RST_VAL(12'hABC),
        .SKID   (0),
        .CNT_W  (16)
    ) u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (ir0),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(ov0),
        .out_ready(out_ready),
        .out_data (od0),
        .stall_cnt(sc0)
    );

    pipe_stage_reg #(
        .WIDTH  (12),
        .RST_VAL(12'h000),
        .SKID   (1),
        .CNT_W  (4)
    ) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (ir1),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(ov1),
        .out_ready(out_ready),
        .out_data (od1),
        .stall_cnt(sc1)
    );

    int checks   = 0;
    int failures = 0;

    localparam int          SK   [2] = '{0, 1};
    localparam int          CMAX [2] = '{65535, 15};
    localparam logic [11:0] RV   [2] = '{12'hABC, 12'h000};

    // Model: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    logic [11:0] mq   [2][$];
    logic        mrdy [2];
    int          mcnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input int k);
        if (SK[k] != 0) return mrdy[k];
        return (mq[k].size() == 0) || out_ready;
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic        ev, er;
            logic [11:0] ed;
            logic        av, ar;
            logic [11:0] ad;
            logic [15:0] ac;
            ev = (mq[k].size() != 0);
            ed = ev ? mq[k][0] : RV[k];
            er = model_ready(k);
            av = (k == 0) ? ov0 : ov1;
            ar = (k == 0) ? ir0 : ir1;
            ad = (k == 0) ? od0 : od1;
            ac = (k == 0) ? sc0 : {12'h000, sc1};
            chk($sformatf("u%0d.out_valid", k), {31'd0, av}, {31'd0, ev});
            chk($sformatf("u%0d.in_ready", k), {31'd0, ar}, {31'd0, er});
            chk($sformatf("u%0d.out_data", k), {20'd0, ad}, {20'd0, ed});
            chk($sformatf("u%0d.stall_cnt", k), {16'd0, ac}, mcnt[k]);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                mrdy[k] = 1'b1;
                mcnt[k] = 0;
            end else begin
                logic fire, ofire;
                fire  = in_valid && model_ready(k);
                ofire = (mq[k].size() != 0) && out_ready;
                if ((mq[k].size() != 0) && !out_ready && (mcnt[k] < CMAX[k])) mcnt[k]++;
                if (ofire) void'(mq[k].pop_front());
                if (fire) mq[k].push_back(in_data);
                if (flush) mq[k].delete();
                mrdy[k] = (mq[k].size() < 2);
            end
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [11:0] d,
                         input logic fl, input logic ordy);
        rst_n     = r;
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Compare on the falling edge, then advance the model across the rising edge.
    task automatic step(input bit do_check);
        @(negedge clk);
        if (do_check) compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        step(1'b0);

        // Reset state
        chk("rst u0.out_valid", {31'd0, ov0}, 0);
        chk("rst u0.out_data", {20'd0, od0}, 32'hABC);
        chk("rst u0.in_ready", {31'd0, ir0}, 1);
        chk("rst u1.in_ready", {31'd0, ir1}, 1);
        chk("rst u1.stall_cnt", {28'd0, sc1}, 0);

        // Streaming, then a single transfer draining to the bubble value
        drive(1'b1, 1'b1, 12'h001, 1'b0, 1'b1); step(1'b1);
        chk("stream1 u0.out_data", {20'd0, od0}, 1);
        chk("stream1 u1.out_data", {20'd0, od1}, 1);
        drive(1'b1, 1'b1, 12'h002, 1'b0, 1'b1); step(1'b1);
        chk("stream2 u0.out_data", {20'd0, od0}, 2);
        chk("stream2 u0.in_ready", {31'd0, ir0}, 1);
        drive(1'b1, 1'b1, 12'h003, 1'b0, 1'b1); step(1'b1);
        chk("stream3 u0.out_data", {20'd0, od0}, 3);
        chk("stream3 u1.out_data", {20'd0, od1}, 3);
        drive(1'b1, 1'b1, 12'h123, 1'b0, 1'b1); step(1'b1);
        chk("single u0.out_data", {20'd0, od0}, 32'h123);
        drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b1); step(1'b1);
        chk("drain u0.out_valid", {31'd0, ov0}, 0);
        chk("drain u0.out_data", {20'd0, od0}, 32'hABC);
        chk("drain u1.out_data", {20'd0, od1}, 0);

        // Reset while the skid buffer is full
        drive(1'b1, 1'b1, 12'h0A1, 1'b0, 1'b0); step(1'b1);
        drive(1'b1, 1'b1, 12'h0A2, 1'b0, 1'b0); step(1'b1);
        chk("full u1.in_ready", {31'd0, ir1}, 0);
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0); step(1'b1);
        chk("midrst u1.out_valid", {31'd0, ov1}, 0);
        chk("midrst u1.out_data", {20'd0, od1}, 0);
        chk("midrst u1.in_ready", {31'd0, ir1}, 1);
        chk("midrst u1.stall_cnt", {28'd0, sc1}, 0);

        // Backpressure: fill, hold, drain in order
        drive(1'b1, 1'b1, 12'h0A1, 1'b0, 1'b0); step(1'b1);
        drive(1'b1, 1'b1, 12'h0A2, 1'b0, 1'b0); step(1'b1);
        chk("bp u1.in_ready", {31'd0, ir1}, 0);
        chk("bp u1.out_data", {20'd0, od1}, 32'hA1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0); step(1'b1);
        end
        chk("bp u1.stall_cnt", {28'd0, sc1}, 5);
        chk("bp u0.stall_cnt", {16'd0, sc0}, 5);
        drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b1); step(1'b1);
        chk("bp drain1 u1.out_data", {20'd0, od1}, 32'hA2);
        chk("bp drain1 u0.out_data", {20'd0, od0}, 32'hABC);
        step(1'b1);
        chk("bp drain2 u1.out_valid", {31'd0, ov1}, 0);
        chk("bp drain2 u1.out_data", {20'd0, od1}, 0);

        // Flush while full with a payload presented
        drive(1'b1, 1'b1, 12'h0A1, 1'b0, 1'b0); step(1'b1);
        drive(1'b1, 1'b1, 12'h0A2, 1'b0, 1'b0); step(1'b1);
        drive(1'b1, 1'b1, 12'h055, 1'b1, 1'b0); step(1'b1);
        chk("flush u1.out_valid", {31'd0, ov1}, 0);
        chk("flush u1.out_data", {20'd0, od1}, 0);
        chk("flush u1.in_ready", {31'd0, ir1}, 1);
        chk("flush u0.out_data", {20'd0, od0}, 32'hABC);
        // Flush discards a payload accepted in the same cycle
        drive(1'b1, 1'b1, 12'h077, 1'b1, 1'b1); step(1'b1);
        chk("flushfire u0.out_valid", {31'd0, ov0}, 0);
        chk("flushfire u1.out_valid", {31'd0, ov1}, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b1); step(1'b1);
        end

        // Saturation of the 4-bit counter
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0); step(1'b1);
        drive(1'b1, 1'b1, 12'h05A, 1'b0, 1'b0); step(1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0); step(1'b1);
        end
        chk("sat u1.stall_cnt", {28'd0, sc1}, 15);
        chk("sat u0.stall_cnt", {16'd0, sc0}, 20);
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("sat hold u1.stall_cnt", {28'd0, sc1}, 15);
        chk("sat hold u0.stall_cnt", {16'd0, sc0}, 23);

        // Randomised traffic with phases of varying downstream pressure
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 250) % 3 == 0) ? 20 : (((i / 250) % 3 == 1) ? 50 : 90);
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 99) < 60,
                  12'($urandom),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) < rdy_pct);
            step(1'b1);
        end
        step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
